// File: rtl/if_stage_pkg.sv
// Shared CPU definitions for the instruction-fetch stage.
//   RESET_PC      : first fetch address after reset
//   fetch_state_t : fetch FSM state encoding
//   pc_inc        : sequential next PC, wrapping modulo 2^32
package if_stage_pkg;

  localparam logic [31:0] RESET_PC = 32'h1C00_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2,
    HOLD = 2'd3
  } fetch_state_t;

  function automatic logic [31:0] pc_inc(input logic [31:0] pc);
    // 32-bit result width discards the carry, so 0xFFFFFFFC wraps to 0.
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/if_stage.sv
// Instruction-fetch stage: issues single-word fetches to a synchronous
// instruction SRAM and presents each word to decode with a valid/ready
// handshake. A one-entry buffer holds the word while decode stalls.
// Ports:
//   clk, resetn                       clock, async active-low reset
//   inst_sram_en/we/addr/wdata        SRAM request (read-only: we/wdata tied 0)
//   inst_sram_rdata                   SRAM read data, one cycle after request
//   br_valid, br_target               redirect pulse and target PC
//   out_valid, out_ready              handshake towards decode
//   out_pc, out_inst, out_adef        presented PC, word, misaligned-fetch flag
module if_stage
  import if_stage_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  output logic        inst_sram_en,
  output logic        inst_sram_we,
  output logic [31:0] inst_sram_addr,
  output logic [31:0] inst_sram_wdata,
  input  logic [31:0] inst_sram_rdata,
  input  logic        br_valid,
  input  logic [31:0] br_target,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_inst,
  output logic        out_adef
);

  fetch_state_t r_state, w_state_nxt;
  logic [31:0]  r_pc, w_pc_nxt;
  logic [31:0]  r_buf, w_buf_nxt;
  logic         r_adef, w_adef_nxt;
  logic         w_aligned;
  logic         w_hs;

  assign w_aligned       = (r_pc[1:0] == 2'b00);
  assign inst_sram_we    = 1'b0;
  assign inst_sram_wdata = 32'h0;
  assign inst_sram_addr  = r_pc;
  assign out_pc          = r_pc;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= IDLE;
      r_pc    <= RESET_PC;
      r_buf   <= 32'h0;
      r_adef  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_buf   <= w_buf_nxt;
      r_adef  <= w_adef_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_pc_nxt     = r_pc;
    w_buf_nxt    = r_buf;
    w_adef_nxt   = r_adef;
    inst_sram_en = 1'b0;
    out_valid    = 1'b0;
    out_inst     = r_buf;
    out_adef     = r_adef;
    w_hs         = 1'b0;

    unique case (r_state)
      IDLE: begin
        w_state_nxt = REQ;
      end
      REQ: begin
        // The request still issues when a redirect arrives this cycle; the
        // redirect sends us back to REQ so its response is never consumed.
        inst_sram_en = w_aligned;
        if (w_aligned) begin
          w_state_nxt = RESP;
        end else begin
          w_state_nxt = HOLD;
          w_buf_nxt   = 32'h0;
          w_adef_nxt  = 1'b1;
        end
      end
      RESP: begin
        out_valid = ~br_valid;
        out_inst  = inst_sram_rdata;
        out_adef  = 1'b0;
        w_hs      = out_valid & out_ready;
        if (w_hs) begin
          w_pc_nxt    = pc_inc(r_pc);
          w_state_nxt = REQ;
        end else begin
          w_buf_nxt   = inst_sram_rdata;
          w_adef_nxt  = 1'b0;
          w_state_nxt = HOLD;
        end
      end
      HOLD: begin
        out_valid = ~br_valid;
        w_hs      = out_valid & out_ready;
        if (w_hs) begin
          w_pc_nxt    = pc_inc(r_pc);
          w_state_nxt = REQ;
        end
      end
      default: w_state_nxt = IDLE;
    endcase

    // Redirect wins over everything outside IDLE and drops any held word.
    if (br_valid && r_state != IDLE) begin
      w_pc_nxt    = br_target;
      w_state_nxt = REQ;
      w_buf_nxt   = 32'h0;
      w_adef_nxt  = 1'b0;
    end
  end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: resetn  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port: inst_sram_en  output  1  fetch request strobe to instruction SRAM.
REQ-004 SHALL have port: inst_sram_we  output  1  instruction SRAM write enable; tied 0.
REQ-005 SHALL have port: inst_sram_addr  output  32  fetch address; equals pc.
REQ-006 SHALL have port: inst_sram_wdata  output  32  tied 0.
REQ-007 SHALL have port: inst_sram_rdata  input  32  read data, valid the cycle after the request.
REQ-008 SHALL have port: br_valid  input  1  one-cycle redirect pulse from the decode/execute FSM.
REQ-009 SHALL have port: br_target  input  32  redirect PC, sampled when br_valid=1.
REQ-010 SHALL have port: out_valid  output  1  fetched instruction presented to decode.
REQ-011 SHALL have port: out_ready  input  1  decode accepts; transfer when out_valid and out_ready are both 1.
REQ-012 SHALL have port: out_pc  output  32  PC of presented instruction.
REQ-013 SHALL have port: out_inst  output  32  presented instruction word.
REQ-014 SHALL have port: out_adef  output  1  presented slot is a misaligned-fetch exception; out_inst=0.

Function
REQ-015 SHALL implement FSM states IDLE, REQ, RESP, HOLD.
REQ-016 IDLE SHALL last exactly one cycle after resetn deasserts, then go to REQ.
REQ-017 In REQ with pc[1:0]==0, the block SHALL assert inst_sram_en=1, drive addr=pc, and go to RESP.
REQ-018 In REQ with pc[1:0]!=0, inst_sram_en SHALL stay 0, and the block SHALL go to HOLD with the buffer set to inst=0, adef=1.
REQ-019 RESP SHALL drive out_valid=1, out_inst=inst_sram_rdata, out_pc=pc, out_adef=0.
REQ-020 On handshake in RESP, the block SHALL set pc<=pc+4 and go to REQ.
REQ-021 Without handshake in RESP, the block SHALL capture rdata into a 32-bit buffer and go to HOLD.
REQ-022 HOLD SHALL present the buffer contents; on handshake it SHALL set pc<=pc+4 and go to REQ; otherwise it SHALL remain in HOLD with outputs stable.
REQ-023 br_valid SHALL override every other event in any state except IDLE: it sets pc<=br_target, forces out_valid=0 that cycle (no handshake), discards any in-flight or buffered instruction, and goes to REQ.
REQ-024 br_valid in REQ SHALL still let that cycle's SRAM request issue; its response SHALL be ignored.
REQ-025 pc+4 SHALL wrap modulo 2^32: 0xFFFFFFFC -> 0x00000000.
REQ-026 Fetch-to-present latency SHALL be 2 cycles (REQ, RESP); sustained throughput SHALL be 1 instruction per 2 cycles with out_ready held at 1.
REQ-027 out_valid SHALL be 1 only in RESP and HOLD; out_pc/out_inst SHALL be don't-care when out_valid=0, but inst_sram_en SHALL never be X.

Reset
REQ-028 resetn low SHALL asynchronously force: state=IDLE, pc=0x1C000000, buffer=0, adef=0, out_valid=0, inst_sram_en=0.
REQ-029 Reset asserted mid-fetch SHALL drop the outstanding response, and after release the first request SHALL be to 0x1C000000.

Structure
REQ-030 The reset PC constant (0x1C000000) and the FSM state encodings SHALL live in the shared CPU definitions package/header.
REQ-031 The block SHALL be a single module with no sub-module; the holding buffer and the FSM are inline.

Verification
REQ-032 Reset release, out_ready=1, rdata=addr^0xA5A5A5A5: first request at cycle 2 to 0x1C000000 -> presented at 0x1C000000 and 0x1C000004 on consecutive RESP cycles, two cycles apart.
REQ-033 out_ready=0 for 5 cycles during RESP, rdata changes afterward: out_inst holds the captured word in HOLD -> handshake, then next request to pc+4.
REQ-034 br_valid with br_target=0x1C000100 asserted in HOLD with out_ready=1 the same cycle: no transfer -> next request to 0x1C000100, buffered word never presented.
REQ-035 br_target=0x1C000102: no SRAM request -> out_valid=1, out_adef=1, out_pc=0x1C000102, out_inst=0.
REQ-036 pc=0xFFFFFFFC accepted -> next request address 0x00000000.
REQ-037 resetn pulsed low in RESP -> out_valid=0 immediately (asynchronously), IDLE, then refetch from 0x1C000000.
